// File: rtl/reg_sc_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_sc_pkg
// Brief  : FSM state type and register field offsets for reg_sc_pulser.
// Rev    : 1.0  initial release
// ============================================================================
package reg_sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam int DEF_NCH  = 4;
  localparam int DEF_CNTW = 8;

  // Field layout, LSB first: TRIG | DLY | LEN | RPT | spare storage
  function automatic int trig_lsb(input int nch);
    return 0;
  endfunction

  function automatic int dly_lsb(input int nch);
    return nch;
  endfunction

  function automatic int len_lsb(input int nch, input int cntw);
    return nch + cntw;
  endfunction

  function automatic int rpt_bit(input int nch, input int cntw);
    return nch + 2 * cntw;
  endfunction

  function automatic int min_width(input int nch, input int cntw);
    return nch + 2 * cntw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : sc_shift_reg
// Brief  : Serial shifter plus parallel register with latch-in / latch-out.
// Rev    : 1.0  initial release
// ============================================================================
module sc_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             bclk,
  input  logic             rstb,
  input  logic             clkEn,
  input  logic             shiftEn,
  input  logic             shiftIn,
  input  logic             latchIn,
  input  logic             latchOut,
  output logic             shiftOut,
  output logic [WIDTH-1:0] shift_word,
  output logic [WIDTH-1:0] reg_word
);

  // latchIn outranks latchOut, which outranks shiftEn
  always_ff @(posedge bclk) begin
    if (!rstb) begin
      shift_word <= '0;
      reg_word   <= '0;
    end else if (clkEn) begin
      if (latchIn) begin
        reg_word <= shift_word;
      end else if (latchOut) begin
        shift_word <= reg_word;
      end else if (shiftEn) begin
        shift_word <= {shift_word[WIDTH-2:0], shiftIn};
      end
    end
  end

  assign shiftOut = shift_word[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/reg_sc_pulser.sv
`default_nettype none
// ============================================================================
// Module : reg_sc_pulser
// Brief  : Serially configured delayed-pulse generator. Optional continuous
//          repetition via the RPT bit when REG_SC_REPEAT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module reg_sc_pulser
  import reg_sc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = DEF_NCH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic           bclk,
  input  logic           rstb,
  input  logic           clkEn,
  input  logic           shiftEn,
  input  logic           shiftIn,
  output logic           shiftOut,
  input  logic           latchIn,
  input  logic           latchOut,
  output logic [NCH-1:0] pulseOut,
  output logic           busy
);

  localparam int TRIG_LSB = trig_lsb(NCH);
  localparam int DLY_LSB  = dly_lsb(NCH);
  localparam int LEN_LSB  = len_lsb(NCH, CNTW);
  localparam int RPT_BIT  = rpt_bit(NCH, CNTW);

  logic [WIDTH-1:0] shift_word;
  logic [WIDTH-1:0] reg_word;

  sc_shift_reg #(.WIDTH(WIDTH)) u_sc_shift_reg (
    .bclk       (bclk),
    .rstb       (rstb),
    .clkEn      (clkEn),
    .shiftEn    (shiftEn),
    .shiftIn    (shiftIn),
    .latchIn    (latchIn),
    .latchOut   (latchOut),
    .shiftOut   (shiftOut),
    .shift_word (shift_word),
    .reg_word   (reg_word)
  );

  // A launch sees the fields being latched this edge, i.e. the shifter
  logic            launch;
  logic [NCH-1:0]  new_trig;
  logic [CNTW-1:0] new_dly;
  logic [CNTW-1:0] new_len;
  logic [CNTW-1:0] new_lenm1;
  logic [NCH-1:0]  cur_trig;
  logic [CNTW-1:0] cur_dly;
  logic [CNTW-1:0] cur_len;
  logic [CNTW-1:0] cur_lenm1;

  assign launch    = clkEn & latchIn;
  assign new_trig  = shift_word[TRIG_LSB +: NCH];
  assign new_dly   = shift_word[DLY_LSB +: CNTW];
  assign new_len   = shift_word[LEN_LSB +: CNTW];
  assign new_lenm1 = (new_len == '0) ? '0 : new_len - CNTW'(1);
  assign cur_trig  = reg_word[TRIG_LSB +: NCH];
  assign cur_dly   = reg_word[DLY_LSB +: CNTW];
  assign cur_len   = reg_word[LEN_LSB +: CNTW];
  assign cur_lenm1 = (cur_len == '0) ? '0 : cur_len - CNTW'(1);

`ifdef REG_SC_REPEAT_EN
  logic cur_rpt;
  assign cur_rpt = reg_word[RPT_BIT];
`endif

  logic unused_fields;
  assign unused_fields = ^{reg_word, shift_word, RPT_BIT[0]};

  state_t          state;
  state_t          state_nxt;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [NCH-1:0]  pulse_nxt;
  logic            busy_nxt;

  always_ff @(posedge bclk) begin
    if (!rstb) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pulseOut <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pulseOut <= pulse_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (launch) begin
      if (new_trig == '0) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else if (new_dly != '0) begin
        state_nxt = ST_DELAY;
        cnt_nxt   = new_dly;
      end else begin
        state_nxt = ST_PULSE;
        cnt_nxt   = new_lenm1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_DELAY: begin
          if (cnt <= CNTW'(1)) begin
            state_nxt = ST_PULSE;
            cnt_nxt   = cur_lenm1;
          end else begin
            cnt_nxt = cnt - CNTW'(1);
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
`ifdef REG_SC_REPEAT_EN
            if (cur_rpt && (cur_dly != '0)) begin
              state_nxt = ST_DELAY;
              cnt_nxt   = cur_dly;
            end else if (cur_rpt) begin
              state_nxt = ST_PULSE;
              cnt_nxt   = cur_lenm1;
            end else begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
`else
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
`endif
          end else begin
            cnt_nxt = cnt - CNTW'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs trail the state by one edge; a TRIG=0 latch silences them at once
  always_comb begin
    pulse_nxt = (state == ST_PULSE) ? cur_trig : '0;
    busy_nxt  = (state != ST_IDLE);
    if (launch && (new_trig == '0)) begin
      pulse_nxt = '0;
      busy_nxt  = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_sc_pulser.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_sc_pulser
// Brief  : Directed bench for reg_sc_pulser with a per-cycle reference model.
//          Honours REG_SC_REPEAT_EN the same way as the design.
// Rev    : 1.0  initial release
// ============================================================================
module tb_reg_sc_pulser;

  localparam int W    = 32;
  localparam int NCH  = 4;
  localparam int CNTW = 8;

  logic           bclk = 1'b0;
  logic           rstb = 1'b0;
  logic           clkEn = 1'b0;
  logic           shiftEn = 1'b0;
  logic           shiftIn = 1'b0;
  logic           latchIn = 1'b0;
  logic           latchOut = 1'b0;
  logic           shiftOut;
  logic [NCH-1:0] pulseOut;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  reg_sc_pulser #(.WIDTH(W), .NCH(NCH), .CNTW(CNTW)) dut (
    .bclk     (bclk),
    .rstb     (rstb),
    .clkEn    (clkEn),
    .shiftEn  (shiftEn),
    .shiftIn  (shiftIn),
    .shiftOut (shiftOut),
    .latchIn  (latchIn),
    .latchOut (latchOut),
    .pulseOut (pulseOut),
    .busy     (busy)
  );

  always #5 bclk = ~bclk;

  // Model: a launched sequence is described by its age t (edges since the
  // launch edge); the outputs at age t follow from DLY, LEN' and RPT alone.
  typedef struct {
    logic [W-1:0]   sh;
    logic [W-1:0]   rg;
    bit             have;
    int             t;
    logic [NCH-1:0] trig;
    int             d;
    int             l;
    bit             rpt;
    logic [NCH-1:0] pulse;
    bit             busy;
  } model_t;

  model_t m;

  function automatic model_t step(input model_t cur, input logic r, input logic ce,
                                  input logic se, input logic si, input logic li,
                                  input logic lo);
    model_t n;
    int     p;
    bit     rep;
    bit     on;
    n = cur;
    if (!r) begin
      n.sh = '0; n.rg = '0; n.have = 0; n.pulse = '0; n.busy = 0;
      return n;
    end
    if (cur.have) begin
      n.t = cur.t + 1;
      p   = n.d + n.l;
`ifdef REG_SC_REPEAT_EN
      rep = n.rpt;
`else
      rep = 0;
`endif
      if (rep) begin
        n.busy = 1;
        on     = ((n.t - 1) % p) >= n.d;
      end else begin
        n.busy = (n.t <= p);
        on     = (n.t - 1 >= n.d) && (n.t - 1 < p);
        if (n.t > p) n.have = 0;
      end
      n.pulse = on ? n.trig : '0;
    end else begin
      n.pulse = '0;
      n.busy  = 0;
    end
    if (ce && li) begin
      n.rg = cur.sh;
      if (cur.sh[NCH-1:0] == '0) begin
        n.have = 0; n.pulse = '0; n.busy = 0;
      end else begin
        n.have = 1;
        n.t    = 0;
        n.trig = cur.sh[NCH-1:0];
        n.d    = int'(cur.sh[NCH +: CNTW]);
        n.l    = (cur.sh[NCH+CNTW +: CNTW] == '0) ? 1 : int'(cur.sh[NCH+CNTW +: CNTW]);
        n.rpt  = cur.sh[NCH+2*CNTW];
      end
    end else if (ce && lo) begin
      n.sh = cur.rg;
    end else if (ce && se) begin
      n.sh = {cur.sh[W-2:0], si};
    end
    return n;
  endfunction

  always @(posedge bclk) m <= step(m, rstb, clkEn, shiftEn, shiftIn, latchIn, latchOut);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge bclk) begin
    if (chk_on) begin
      check("model_pulseOut", 32'(pulseOut), 32'(m.pulse));
      check("model_busy", 32'(busy), 32'(m.busy));
      check("model_shiftOut", 32'(shiftOut), 32'(m.sh[W-1]));
    end
  end

  // One clock: inputs set after a falling edge, held across the rising edge
  task automatic cyc(input logic se, input logic si, input logic li, input logic lo,
                     input logic ce);
    shiftEn = se; shiftIn = si; latchIn = li; latchOut = lo; clkEn = ce;
    @(negedge bclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  task automatic load(input logic [W-1:0] word);
    for (int i = W - 1; i >= 0; i--) cyc(1, word[i], 0, 0, 1);
  endtask

  task automatic latch();
    cyc(0, 0, 1, 0, 1);
  endtask

  logic [NCH-1:0] rpt_pulse_exp;
  logic           rpt_busy_exp;
  logic [31:0]    rb;

  initial begin
`ifdef REG_SC_REPEAT_EN
    rpt_pulse_exp = 4'h9;
    rpt_busy_exp  = 1'b1;
`else
    rpt_pulse_exp = 4'h0;
    rpt_busy_exp  = 1'b0;
`endif
    @(negedge bclk);
    idle(3);
    check("reset_pulse", 32'(pulseOut), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_shiftOut", 32'(shiftOut), 0);
    rstb   = 1'b1;
    chk_on = 1'b1;

    // DLY=0, LEN=1 single pulse
    load(32'h0000_1001); latch();
    check("single_j0", 32'(pulseOut), 0);
    idle(1);
    check("single_j1", 32'(pulseOut), 32'h1);
    check("single_busy_j1", 32'(busy), 1);
    idle(1);
    check("single_j2", 32'(pulseOut), 0);
    check("single_busy_j2", 32'(busy), 0);

    // DLY=5, LEN=3
    load(32'h0000_305A); latch();
    check("dly5_busy_j0", 32'(busy), 0);
    idle(1); check("dly5_busy_j1", 32'(busy), 1);
    idle(4); check("dly5_j5", 32'(pulseOut), 0);
    idle(1); check("dly5_j6", 32'(pulseOut), 32'hA);
    idle(2); check("dly5_j8", 32'(pulseOut), 32'hA);
    check("dly5_busy_j8", 32'(busy), 1);
    idle(1); check("dly5_j9", 32'(pulseOut), 0);
    check("dly5_busy_j9", 32'(busy), 0);

    // Readback through latchOut
    load(32'hA5C3_0F00); latch();
    load(32'h1234_5670);
    cyc(0, 0, 0, 1, 1);
    for (int i = W - 1; i >= 0; i--) begin
      rb[i] = shiftOut;
      cyc(1, 0, 0, 0, 1);
    end
    check("readback", rb, 32'hA5C3_0F00);

    // Relaunch during DELAY: two shifts turn 0x0803 into 0x200C (TRIG=C, DLY=0, LEN=2)
    load(32'h0000_0803); latch();
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    latch();
    check("relaunch_j0", 32'(pulseOut), 0);
    idle(1); check("relaunch_j1", 32'(pulseOut), 32'hC);
    idle(1); check("relaunch_j2", 32'(pulseOut), 32'hC);
    idle(1); check("relaunch_j3", 32'(pulseOut), 0);
    check("relaunch_busy_j3", 32'(busy), 0);
    idle(140);

    // TRIG=0 latch aborts a long pulse
    load(32'h0006_4005); latch();
    idle(2); check("abort_j2", 32'(pulseOut), 32'h5);
    load(32'h0); check("abort_j34", 32'(pulseOut), 32'h5);
    latch();
    check("abort_pulse", 32'(pulseOut), 0);
    check("abort_busy", 32'(busy), 0);
    idle(3);

    // Reset during PULSE
    load(32'h0000_A00F); latch();
    idle(3); check("rst_pre", 32'(pulseOut), 32'hF);
    rstb = 1'b0; idle(1);
    check("rst_pulse", 32'(pulseOut), 0);
    check("rst_busy", 32'(busy), 0);
    rstb = 1'b1; idle(1);
    check("rst_after", 32'(pulseOut), 0);

    // Repeat: RPT=1, DLY=2, LEN=1
    load(32'h0010_1029); latch();
    idle(3); check("rpt_j3", 32'(pulseOut), 32'h9);
    idle(3); check("rpt_j6", 32'(pulseOut), 32'(rpt_pulse_exp));
    check("rpt_busy_j6", 32'(busy), 32'(rpt_busy_exp));
    idle(3); check("rpt_j9", 32'(pulseOut), 32'(rpt_pulse_exp));
    load(32'h0); latch();
    check("rpt_stop", 32'(pulseOut), 0);
    idle(5);

    // Maximum delay
    load(32'h0000_1FF2); latch();
    idle(255); check("maxdly_j255", 32'(pulseOut), 0);
    check("maxdly_busy_j255", 32'(busy), 1);
    idle(1); check("maxdly_j256", 32'(pulseOut), 32'h2);
    idle(1); check("maxdly_j257", 32'(pulseOut), 0);
    check("maxdly_busy_j257", 32'(busy), 0);

    // clkEn low masks every operation
    load(32'h0000_1001);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 0);
    check("clken_busy", 32'(busy), 0);
    cyc(1, 1, 1, 1, 1);
    idle(1); check("clken_latch", 32'(pulseOut), 32'h1);

    // Mixed traffic checked by the model
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 3) != 0));
    idle(4);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 expected");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/reg_sc_pulser.md
REG_SC_PULSER -- requirements
Module: reg_sc_pulser

Interface
REQ-001 Parameter WIDTH, default 32, serial register length; SHALL satisfy WIDTH >= NCH+2*CNTW+1.
REQ-002 Parameter NCH, default 4, number of pulse channels.
REQ-003 Parameter CNTW, default 8, width of the delay and length fields.
REQ-004 bclk  input  1  clock; all logic SHALL be on the rising edge.
REQ-005 rstb  input  1  reset, synchronous, active-low.
REQ-006 clkEn  input  1  qualifies shiftEn, latchIn and latchOut.
REQ-007 shiftEn  input  1  shift shifter one bit toward MSB.
REQ-008 shiftIn  input  1  serial data into shifter bit 0.
REQ-009 shiftOut  output  1  shifter MSB.
REQ-010 latchIn  input  1  copy shifter into register and launch a pulse sequence.
REQ-011 latchOut  input  1  copy register into shifter for readback.
REQ-012 pulseOut  output  NCH  registered pulse outputs.
REQ-013 busy  output  1  high while state is not IDLE.

Function
REQ-014 Register fields SHALL be: TRIG = [NCH-1:0], DLY = [NCH+CNTW-1:NCH], LEN = [NCH+2*CNTW-1:NCH+CNTW], RPT = bit NCH+2*CNTW; remaining bits SHALL be storage only.
REQ-015 Effective operations SHALL require clkEn=1; priority SHALL be latchIn > latchOut > shiftEn; in a latchIn cycle, latchOut and shiftEn SHALL be ignored.
REQ-016 Shift: shifter <= {shifter[WIDTH-2:0], shiftIn}; shiftOut SHALL equal shifter[WIDTH-1] combinationally.
REQ-017 The FSM and counters SHALL run every bclk, independent of clkEn.
REQ-018 FSM states SHALL be IDLE, DELAY, PULSE.
REQ-019 Launch: on an effective latchIn at edge k with TRIG != 0, the FSM SHALL enter DELAY with cnt = DLY if DLY > 0, else PULSE with cnt = LEN'-1; LEN' = max(LEN,1).
REQ-020 In DELAY, cnt SHALL decrement each cycle; at cnt = 1 the FSM SHALL enter PULSE with cnt = LEN'-1.
REQ-021 pulseOut SHALL equal TRIG while in PULSE, else 0; it SHALL first assert after edge k+DLY+1 and stay high for exactly LEN' cycles.
REQ-022 In PULSE at cnt = 0: if RPT=1 (macro enabled), the FSM SHALL re-enter DELAY (or PULSE if DLY = 0) with reloaded counts; otherwise it SHALL enter IDLE.
REQ-023 An effective latchIn with TRIG = 0 SHALL force IDLE and pulseOut = 0 at the next edge.
REQ-024 An effective latchIn while busy SHALL abort the running sequence and relaunch using the new fields; this relaunch SHALL NOT produce a merged pulse unless the new DLY = 0.
REQ-025 Register contents SHALL be unchanged by sequence completion; TRIG SHALL NOT self-clear.
REQ-026 Counter arithmetic SHALL be unsigned CNTW-bit with no wrap; DLY = 2^CNTW-1 SHALL give a maximum delay.

Reset
REQ-027 With rstb = 0 at an edge: shifter, register, cnt and pulseOut SHALL become 0, state SHALL become IDLE, and busy SHALL become 0.
REQ-028 Reset during DELAY or PULSE SHALL abort the sequence at that edge with no trailing pulse.

Configuration
REQ-029 REG_SC_REPEAT_EN defined: RPT SHALL enable continuous repetition per REQ-022.
REQ-030 REG_SC_REPEAT_EN undefined: RPT SHALL be stored and read back but ignored by the FSM, and no repeat logic SHALL be synthesised.

Structure
REQ-031 Package reg_sc_pkg SHALL hold the state typedef and the field-offset functions and constants derived from NCH and CNTW.
REQ-032 The shifter and register SHALL be a sub-module sc_shift_reg (parameter WIDTH); reg_sc_pulser SHALL add the FSM and the counters.

Verification
REQ-033 Shift 32 bits with TRIG=0001, DLY=0, LEN=1, then latchIn -> pulseOut=0001 for exactly one cycle, starting one cycle after the latch edge.
REQ-034 TRIG=1010, DLY=5, LEN=3 -> pulseOut=1010 during cycles k+6..k+8; busy high for cycles k+1..k+8.
REQ-035 latchOut after a load, then shift 32 times -> shiftOut reproduces the loaded word MSB-first.
REQ-036 Relaunch at the 2nd DELAY cycle with DLY=0, LEN=2 -> new pulse at k'+1 for 2 cycles; old pulse never appears.
REQ-037 rstb=0 during PULSE with LEN=10 -> pulseOut=0 and busy=0 after that edge.
REQ-038 With REG_SC_REPEAT_EN: RPT=1, DLY=2, LEN=1 -> pulse every 3 cycles until a latchIn with TRIG=0; without the macro -> a single pulse.
